// File: rtl/rmii_frame_engine.sv
// rmii_frame_engine: MII/RMII TX serialiser and RX deserialiser between MAC byte streams and PHY pins.
module rmii_frame_engine #(
  parameter int MII_W        = 2,
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_BYTES    = 12,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  input  logic             tx_last,
  output logic             tx_ready,
  output logic             tx_underrun,
  output logic             ETH_TXEN,
  output logic [MII_W-1:0] ETH_TXD,
  input  logic             ETH_CRSDV,
  input  logic [MII_W-1:0] ETH_RXD,
  input  logic             ETH_RXERR,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_last,
  output logic             rx_err,
  output logic [CNT_W-1:0] tx_frame_cnt,
  output logic [CNT_W-1:0] rx_frame_cnt,
  output logic [CNT_W-1:0] rx_err_cnt
);
  localparam int S = 8 / MII_W;
  localparam logic [1:0] SL_MAX = 2'(S - 1);
  localparam logic [4:0] PRE_MAX = 5'(PREAMBLE_LEN - 1);
  localparam logic [4:0] IFG_MAX = 5'(IFG_BYTES - 1);
  localparam logic [MII_W-1:0] PRE_SL = MII_W'(8'h55);
  localparam logic [MII_W-1:0] SFD_SL = MII_W'(8'hD5 >> (8 - MII_W));

  typedef enum logic [2:0] {T_IDLE, T_PRE, T_SFD, T_DATA, T_IFG} tx_st_t;
  typedef enum logic [1:0] {R_IDLE, R_PRE, R_DATA} rx_st_t;

  tx_st_t ts;
  logic [1:0] tsl;
  logic [4:0] tbc;
  logic [7:0] tdb;
  logic tlst;
  logic [7:0] tcur;
  logic [2:0] toff;
  logic tend;

  assign tend = tsl == SL_MAX;
  assign tcur = ts == T_PRE ? 8'h55 : ts == T_SFD ? 8'hD5 : tdb;
  assign toff = 3'(tsl * MII_W);
  assign ETH_TXEN = ts inside {T_PRE, T_SFD, T_DATA};
  assign ETH_TXD = ETH_TXEN ? tcur[toff +: MII_W] : '0;
  // Ready only on the final slice of SFD or a data byte, and never after the last byte was taken.
  assign tx_ready = (ts == T_SFD || (ts == T_DATA && !tlst)) && tend;
  assign tx_underrun = tx_ready && !tx_valid;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ts <= T_IDLE;
      tsl <= '0;
      tbc <= '0;
      tdb <= '0;
      tlst <= 1'b0;
      tx_frame_cnt <= '0;
    end else begin
      tsl <= (ts == T_IDLE || tend) ? 2'd0 : tsl + 2'd1;
      case (ts)
        T_IDLE: if (tx_valid) begin
          ts <= T_PRE;
          tbc <= '0;
        end
        T_PRE: if (tend) begin
          tbc <= tbc + 5'd1;
          if (tbc == PRE_MAX) ts <= T_SFD;
        end
        T_SFD, T_DATA: if (tend) begin
          tbc <= '0;
          if (ts == T_DATA && tlst) begin
            ts <= T_IFG;
            tlst <= 1'b0;
            if (~&tx_frame_cnt) tx_frame_cnt <= tx_frame_cnt + CNT_W'(1);
          end else if (tx_valid) begin
            ts <= T_DATA;
            tdb <= tx_data;
            tlst <= tx_last;
          end else begin
            ts <= T_IFG;
          end
        end
        T_IFG: if (tend) begin
          tbc <= tbc + 5'd1;
          if (tbc == IFG_MAX) ts <= T_IDLE;
        end
        default: ts <= T_IDLE;
      endcase
    end
  end

  rx_st_t rs;
  logic [1:0] rsl;
  logic [7-MII_W:0] rsh;
  logic [7:0] hb;
  logic hv;
  logic rerr;
  logic [7:0] rbyte;
  logic rbad;

  assign rbyte = {ETH_RXD, rsh};
  assign rbad = rerr || ETH_RXERR || rsl != 2'd0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rs <= R_IDLE;
      rsl <= '0;
      rsh <= '0;
      hb <= '0;
      hv <= 1'b0;
      rerr <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      rx_last <= 1'b0;
      rx_err <= 1'b0;
      rx_frame_cnt <= '0;
      rx_err_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_last <= 1'b0;
      rx_err <= 1'b0;
      case (rs)
        R_IDLE: begin
          rerr <= 1'b0;
          hv <= 1'b0;
          rsl <= '0;
          if (ETH_CRSDV && ETH_RXD == PRE_SL) rs <= R_PRE;
        end
        R_PRE: if (!ETH_CRSDV) begin
          rs <= R_IDLE;
        end else begin
          rerr <= rerr | ETH_RXERR;
          if (ETH_RXD == SFD_SL) rs <= R_DATA;
        end
        R_DATA: if (!ETH_CRSDV) begin
          rs <= R_IDLE;
          rx_valid <= hv;
          rx_last <= hv;
          rx_err <= hv && rbad;
          if (hv) rx_data <= hb;
          if (~&rx_frame_cnt) rx_frame_cnt <= rx_frame_cnt + CNT_W'(1);
          if ((rbad || !hv) && ~&rx_err_cnt) rx_err_cnt <= rx_err_cnt + CNT_W'(1);
        end else begin
          rerr <= rerr | ETH_RXERR;
          rsh <= rbyte[7:MII_W];
          rsl <= rsl == SL_MAX ? 2'd0 : rsl + 2'd1;
          // One-byte hold so the final byte can carry rx_last when carrier drops.
          if (rsl == SL_MAX) begin
            hb <= rbyte;
            hv <= 1'b1;
            rx_valid <= hv;
            if (hv) rx_data <= hb;
          end
        end
        default: rs <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rmii_frame_engine.sv
// tb_rmii_frame_engine: scoreboard bench for TX serialisation and RX assembly (RMII and MII).
module tb_rmii_frame_engine;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_valid = 1'b0, tx_last = 1'b0;
  logic tx_ready, tx_underrun, ETH_TXEN;
  logic [1:0] ETH_TXD;
  logic crs2 = 1'b0, rxerr2 = 1'b0;
  logic [1:0] rxd2 = '0;
  logic [7:0] rxa_data;
  logic rxa_valid, rxa_last, rxa_err;
  logic [1:0] tx_frame_cnt, rxa_frame_cnt, rxa_err_cnt;
  logic crs4 = 1'b0;
  logic [3:0] rxd4 = '0;
  logic b_ready, b_underrun, b_txen;
  logic [3:0] b_txd;
  logic [7:0] rxb_data;
  logic rxb_valid, rxb_last, rxb_err;
  logic [15:0] b_tx_cnt, rxb_frame_cnt, rxb_err_cnt;

  int checks = 0, errors = 0;
  logic txmon = 1'b1;
  logic [1:0] txq[$];
  logic [9:0] qa[$], qb[$];
  logic [7:0] txb[0:7];
  logic [7:0] rb[0:7];

  always #5 CLK = ~CLK;

  rmii_frame_engine #(.MII_W(2), .CNT_W(2)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .tx_underrun(tx_underrun), .ETH_TXEN(ETH_TXEN), .ETH_TXD(ETH_TXD),
    .ETH_CRSDV(crs2), .ETH_RXD(rxd2), .ETH_RXERR(rxerr2), .rx_data(rxa_data),
    .rx_valid(rxa_valid), .rx_last(rxa_last), .rx_err(rxa_err), .tx_frame_cnt(tx_frame_cnt),
    .rx_frame_cnt(rxa_frame_cnt), .rx_err_cnt(rxa_err_cnt));

  rmii_frame_engine #(.MII_W(4)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .tx_data(8'h00), .tx_valid(1'b0), .tx_last(1'b0),
    .tx_ready(b_ready), .tx_underrun(b_underrun), .ETH_TXEN(b_txen), .ETH_TXD(b_txd),
    .ETH_CRSDV(crs4), .ETH_RXD(rxd4), .ETH_RXERR(1'b0), .rx_data(rxb_data),
    .rx_valid(rxb_valid), .rx_last(rxb_last), .rx_err(rxb_err), .tx_frame_cnt(b_tx_cnt),
    .rx_frame_cnt(rxb_frame_cnt), .rx_err_cnt(rxb_err_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    logic [1:0] e;
    if (txmon) begin
      if (ETH_TXEN) begin
        if (txq.size() == 0) chk("txen_extra", ETH_TXEN, 0);
        else begin
          e = txq.pop_front();
          chk("txd", ETH_TXD, e);
        end
      end else chk("txd_idle", ETH_TXD, 0);
    end
  end

  always @(negedge CLK) begin
    logic [9:0] e;
    if (rxa_valid) begin
      if (qa.size() == 0) chk("rxa_extra", rxa_valid, 0);
      else begin
        e = qa.pop_front();
        chk("rxa_byte", {rxa_last, rxa_err, rxa_data}, e);
      end
    end
    if (rxb_valid) begin
      if (qb.size() == 0) chk("rxb_extra", rxb_valid, 0);
      else begin
        e = qb.pop_front();
        chk("rxb_byte", {rxb_last, rxb_err, rxb_data}, e);
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int p = 0; p < 4; p++) txq.push_back(b[2*p +: 2]);
  endtask

  task automatic tx_frame(input int n, input int ur, output int gap, output int hi,
                          output int rdy, output int und);
    int acc, t, m;
    bit started, done;
    m = ur < n ? ur : n;
    for (int k = 0; k < 7; k++) push_byte(8'h55);
    push_byte(8'hD5);
    for (int k = 0; k < m; k++) push_byte(txb[k]);
    gap = 0; hi = 0; rdy = 0; und = 0; acc = 0; t = 0; started = 0; done = 0;
    tx_data = txb[0];
    tx_last = n == 1;
    tx_valid = 1'b1;
    while (!done && t < 400) begin
      @(negedge CLK);
      t++;
      if (ETH_TXEN) begin
        started = 1;
        hi++;
      end else if (!started) gap++;
      else done = 1;
      if (tx_underrun) und++;
      if (tx_ready) begin
        rdy++;
        if (tx_valid) begin
          @(posedge CLK);
          #1;
          acc++;
          if (acc == n || acc == ur) begin
            tx_valid = 1'b0;
            tx_last = 1'b0;
          end else begin
            tx_data = txb[acc];
            tx_last = acc == n - 1;
          end
        end
      end
    end
    if (!done) chk("tx_timeout", done, 1);
    chk("tx_queue_left", txq.size(), 0);
  endtask

  function automatic logic [3:0] rx_slice(input int w, input int j);
    int s, bi;
    logic [7:0] v;
    s = 8 / w;
    bi = j / s;
    v = bi < 7 ? 8'h55 : bi == 7 ? 8'hD5 : rb[bi-8];
    return 4'((v >> ((j % s) * w)) & ((1 << w) - 1));
  endfunction

  task automatic rx_send(input int w, input int nb, input int extra, input int errat);
    int s, tot;
    bit bad;
    logic [3:0] sl;
    s = 8 / w;
    tot = 8 * s + nb * s + extra;
    bad = errat >= 0 || extra != 0;
    for (int k = 0; k < nb; k++) begin
      if (w == 2) qa.push_back({k == nb - 1, bad && k == nb - 1, rb[k]});
      else qb.push_back({k == nb - 1, bad && k == nb - 1, rb[k]});
    end
    for (int j = 0; j < tot; j++) begin
      @(posedge CLK);
      #1;
      sl = rx_slice(w, j);
      if (w == 2) begin
        crs2 = 1'b1;
        rxd2 = sl[1:0];
        rxerr2 = j == errat;
      end else begin
        crs4 = 1'b1;
        rxd4 = sl;
      end
    end
    @(posedge CLK);
    #1;
    crs2 = 1'b0; rxd2 = '0; rxerr2 = 1'b0; crs4 = 1'b0; rxd4 = '0;
    repeat (4) @(posedge CLK);
  endtask

  initial begin
    int gap, hi, rdy, und;
    logic [3:0] sl;
    repeat (3) @(negedge CLK);
    chk("rst_txen", ETH_TXEN, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_rxvalid", rxa_valid, 0);
    chk("rst_cnts", {tx_frame_cnt, rxa_frame_cnt, rxa_err_cnt}, 0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    txb[0] = 8'h11; txb[1] = 8'h22; txb[2] = 8'h33;
    tx_frame(3, 99, gap, hi, rdy, und);
    chk("tx3_txen_len", hi, 44);
    chk("tx3_ready_pulses", rdy, 3);
    chk("tx3_underrun", und, 0);
    chk("tx3_cnt", tx_frame_cnt, 1);

    txb[0] = 8'h44; txb[1] = 8'h55; txb[2] = 8'h66;
    tx_frame(3, 1, gap, hi, rdy, und);
    chk("ifg_after_frame", (gap + 1 >= 48) && (gap + 1 <= 49), 1);
    chk("ur_txen_len", hi, 36);
    chk("ur_ready_pulses", rdy, 2);
    chk("ur_pulse", und, 1);
    chk("ur_cnt", tx_frame_cnt, 1);

    txb[0] = 8'h77;
    tx_frame(1, 99, gap, hi, rdy, und);
    chk("ifg_after_underrun", (gap + 1 >= 48) && (gap + 1 <= 49), 1);
    chk("tx1_txen_len", hi, 36);
    chk("tx1_cnt", tx_frame_cnt, 2);

    rb[0] = 8'hA5; rb[1] = 8'h3C;
    rx_send(4, 2, 0, -1);
    chk("rxb_frames", rxb_frame_cnt, 1);
    chk("rxb_errs", rxb_err_cnt, 0);

    rb[0] = 8'h12; rb[1] = 8'h34; rb[2] = 8'h56;
    rx_send(2, 3, 0, 37);
    rb[0] = 8'h9A; rb[1] = 8'hBC; rb[2] = 8'hEF;
    rx_send(2, 2, 1, -1);
    chk("rxa_frames", rxa_frame_cnt, 2);
    chk("rxa_errs", rxa_err_cnt, 2);

    txmon = 1'b0;
    rb[0] = 8'hC7; rb[1] = 8'h18;
    @(posedge CLK);
    #1;
    tx_data = 8'h00; tx_last = 1'b0; tx_valid = 1'b1;
    for (int j = 0; j < 38; j++) begin
      @(posedge CLK);
      #1;
      sl = rx_slice(2, j);
      crs2 = 1'b1;
      rxd2 = sl[1:0];
    end
    #2;
    chk("pre_rst_txen", ETH_TXEN, 1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_txen", ETH_TXEN, 0);
    chk("rst_mid_cnts", {tx_frame_cnt, rxa_frame_cnt, rxa_err_cnt}, 0);
    tx_valid = 1'b0; crs2 = 1'b0; rxd2 = '0;
    repeat (2) @(posedge CLK);
    #2;
    RST_N = 1'b1;
    txq.delete();
    @(negedge CLK);
    txmon = 1'b1;
    repeat (6) @(negedge CLK);

    txb[0] = 8'h11; txb[1] = 8'h22; txb[2] = 8'h33;
    tx_frame(3, 99, gap, hi, rdy, und);
    chk("post_rst_txen_len", hi, 44);
    chk("post_rst_cnt", tx_frame_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      txb[0] = 8'h80 + 8'(i);
      tx_frame(1, 99, gap, hi, rdy, und);
      chk("sat_ifg", (gap + 1 >= 48) && (gap + 1 <= 49), 1);
      chk("sat_cnt", tx_frame_cnt, i + 2 > 3 ? 3 : i + 2);
    end

    rb[0] = 8'h5A; rb[1] = 8'hC3;
    rx_send(2, 2, 0, -1);
    chk("post_rst_rx_frames", rxa_frame_cnt, 1);
    chk("post_rst_rx_errs", rxa_err_cnt, 0);

    repeat (4) @(negedge CLK);
    chk("qa_empty", qa.size(), 0);
    chk("qb_empty", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got running expected finished");
    $fatal(1);
  end
endmodule
